// File: rtl/dual_mac_pkg.sv
// dual_mac_pkg: shared constants, frame-state encoding and output scaling helper for dual_mac_frame.
// Latency: n/a (package).
// Backpressure: n/a (package).

package dual_mac_pkg;

    // Cycles from a last sample on the inputs to out_valid in the default build.
    localparam int LAT_BASE = 4;

    // Working width of the scaling helper; ACC_W must stay below this.
    localparam int SCALE_W = 128;

    typedef enum logic {
        FIRST = 1'b0,
        ACCUM = 1'b1
    } frame_state_e;

    // Scale a sign-extended accumulator down by 'shift' into an out_w-bit result.
    // rnd_sat=0: floor and wrap, flag set when the discarded upper bits are not sign copies.
    // rnd_sat=1: round half up and clamp to the out_w signed range, flag set on clamping.
    // Returns {flag, result sign-extended to SCALE_W}.
    function automatic logic [SCALE_W:0] scale_acc(
        input logic signed [SCALE_W-1:0] acc,
        input int                        out_w,
        input int                        shift,
        input logic                      rnd_sat
    );
        logic signed [SCALE_W-1:0] one;
        logic signed [SCALE_W-1:0] q;
        logic signed [SCALE_W-1:0] hi;
        logic signed [SCALE_W-1:0] lo;
        logic signed [SCALE_W-1:0] res;
        logic                      flag;
        one  = {{(SCALE_W-1){1'b0}}, 1'b1};
        hi   = (one <<< (out_w - 1)) - one;
        lo   = ~hi;
        flag = 1'b0;
        q    = acc >>> shift;
        if (rnd_sat && (shift > 0)) begin
            q = (acc + (one <<< (shift - 1))) >>> shift;
        end
        if (rnd_sat) begin
            if (q > hi) begin
                res  = hi;
                flag = 1'b1;
            end else if (q < lo) begin
                res  = lo;
                flag = 1'b1;
            end else begin
                res = q;
            end
        end else begin
            res  = (q <<< (SCALE_W - out_w)) >>> (SCALE_W - out_w);
            flag = (res != q);
        end
        return {flag, res};
    endfunction

endpackage

// File: rtl/dual_mac_scale.sv
// dual_mac_scale: turns a finished frame accumulator into the registered p/out_count/ovf outputs.
// Latency: 1 cycle (2 with DUAL_MAC_ROUND_SAT_EN, which adds a capture stage ahead of round/saturate).
// Backpressure: none; every fire_vld pulse produces one out_valid pulse.

module dual_mac_scale #(
    parameter int ACC_W = 48,
    parameter int OUT_W = 32,
    parameter int SHIFT = 16,
    parameter int CNT_W = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    fire_vld,
    input  logic signed [ACC_W-1:0] acc_dat,
    input  logic                    acc_ovf,
    input  logic [CNT_W-1:0]        cnt_dat,
    output logic signed [OUT_W-1:0] p,
    output logic                    out_valid,
    output logic [CNT_W-1:0]        out_count,
    output logic                    ovf
);
    import dual_mac_pkg::*;

    logic                    src_vld;
    logic                    src_ovf;
    logic signed [ACC_W-1:0] src_acc;
    logic [CNT_W-1:0]        src_cnt;
    logic                    rnd_sat;

`ifdef DUAL_MAC_ROUND_SAT_EN
    logic                    stg_vld_q, stg_vld_d;
    logic                    stg_ovf_q, stg_ovf_d;
    logic signed [ACC_W-1:0] stg_acc_q, stg_acc_d;
    logic [CNT_W-1:0]        stg_cnt_q, stg_cnt_d;

    // Capture the finished frame so the rounding adder and clamp get a cycle of their own.
    always_comb begin
        stg_vld_d = fire_vld;
        stg_ovf_d = stg_ovf_q;
        stg_acc_d = stg_acc_q;
        stg_cnt_d = stg_cnt_q;
        if (fire_vld) begin
            stg_ovf_d = acc_ovf;
            stg_acc_d = acc_dat;
            stg_cnt_d = cnt_dat;
        end
    end

    // Capture-stage registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stg_vld_q <= 1'b0;
            stg_ovf_q <= 1'b0;
            stg_acc_q <= '0;
            stg_cnt_q <= '0;
        end else begin
            stg_vld_q <= stg_vld_d;
            stg_ovf_q <= stg_ovf_d;
            stg_acc_q <= stg_acc_d;
            stg_cnt_q <= stg_cnt_d;
        end
    end

    assign src_vld = stg_vld_q;
    assign src_ovf = stg_ovf_q;
    assign src_acc = stg_acc_q;
    assign src_cnt = stg_cnt_q;
    assign rnd_sat = 1'b1;
`else
    assign src_vld = fire_vld;
    assign src_ovf = acc_ovf;
    assign src_acc = acc_dat;
    assign src_cnt = cnt_dat;
    assign rnd_sat = 1'b0;
`endif

    logic signed [SCALE_W-1:0] acc_ext;
    logic [SCALE_W:0]          sc;
    logic                      sc_ovf;
    logic                      unused_sc_hi;

    assign acc_ext = {{(SCALE_W-ACC_W){src_acc[ACC_W-1]}}, src_acc};
    assign sc      = scale_acc(acc_ext, OUT_W, SHIFT, rnd_sat);
    assign sc_ovf  = sc[SCALE_W];
    // Above OUT_W the helper result is only sign copies; fold them so they read as consumed.
    assign unused_sc_hi = ^sc[SCALE_W-1:OUT_W];

    logic signed [OUT_W-1:0] p_q, p_d;
    logic                    out_valid_q, out_valid_d;
    logic [CNT_W-1:0]        out_count_q, out_count_d;
    logic                    ovf_q, ovf_d;

    // Output registers load on a finished frame and hold until the next one.
    always_comb begin
        out_valid_d = src_vld;
        p_d         = p_q;
        out_count_d = out_count_q;
        ovf_d       = ovf_q;
        if (src_vld) begin
            p_d         = sc[OUT_W-1:0];
            out_count_d = src_cnt;
            ovf_d       = src_ovf | sc_ovf;
        end
    end

    // Output register state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p_q         <= '0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            ovf_q       <= ovf_d;
        end
    end

    assign p         = p_q;
    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign ovf       = ovf_q;

endmodule

// File: rtl/dual_mac_frame.sv
// dual_mac_frame: per-sample (a*b)+/-(c*d) accumulated over an in_last-delimited frame; one scaled result per frame.
// Latency: 4 cycles from last sample to out_valid (5 with build macro DUAL_MAC_ROUND_SAT_EN: round-half-up + saturate).
// Backpressure: none; a sample is taken every cycle in_valid is high, gaps inside a frame are allowed.

module dual_mac_frame #(
    parameter int A_W   = 26,
    parameter int B_W   = 18,
    parameter int ACC_W = 48,
    parameter int OUT_W = 32,
    parameter int SHIFT = 16,
    parameter int CNT_W = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic                    sub,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    input  logic signed [A_W-1:0]   c,
    input  logic signed [B_W-1:0]   d,
    output logic signed [OUT_W-1:0] p,
    output logic                    out_valid,
    output logic [CNT_W-1:0]        out_count,
    output logic                    ovf
);
    import dual_mac_pkg::*;

    localparam int PW = A_W + B_W;

    // Stage 1: registered inputs.
    logic                  vld1_q, vld1_d, last1_q, last1_d, sub1_q, sub1_d;
    logic signed [A_W-1:0] a1_q, a1_d, c1_q, c1_d;
    logic signed [B_W-1:0] b1_q, b1_d, d1_q, d1_d;
    // Stage 2: products.
    logic                  vld2_q, vld2_d, last2_q, last2_d, sub2_q, sub2_d;
    logic signed [PW-1:0]  ab2_q, ab2_d, cd2_q, cd2_d;
    // Stage 3: combined sample, already at accumulator width.
    logic                    vld3_q, vld3_d, last3_q, last3_d;
    logic signed [ACC_W-1:0] sum3_q, sum3_d;

    // Datapath next values: register, multiply, then add or subtract the two products.
    always_comb begin
        vld1_d  = in_valid;
        last1_d = in_valid & in_last;
        sub1_d  = sub;
        a1_d    = a;
        b1_d    = b;
        c1_d    = c;
        d1_d    = d;

        vld2_d  = vld1_q;
        last2_d = last1_q;
        sub2_d  = sub1_q;
        ab2_d   = PW'(a1_q) * PW'(b1_q);
        cd2_d   = PW'(c1_q) * PW'(d1_q);

        vld3_d  = vld2_q;
        last3_d = last2_q;
        if (sub2_q) begin
            sum3_d = ACC_W'(ab2_q) - ACC_W'(cd2_q);
        end else begin
            sum3_d = ACC_W'(ab2_q) + ACC_W'(cd2_q);
        end
    end

    // Pipeline registers; only the valid bits matter after reset but data is cleared too.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld1_q  <= 1'b0;
            last1_q <= 1'b0;
            sub1_q  <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
            c1_q    <= '0;
            d1_q    <= '0;
            vld2_q  <= 1'b0;
            last2_q <= 1'b0;
            sub2_q  <= 1'b0;
            ab2_q   <= '0;
            cd2_q   <= '0;
            vld3_q  <= 1'b0;
            last3_q <= 1'b0;
            sum3_q  <= '0;
        end else begin
            vld1_q  <= vld1_d;
            last1_q <= last1_d;
            sub1_q  <= sub1_d;
            a1_q    <= a1_d;
            b1_q    <= b1_d;
            c1_q    <= c1_d;
            d1_q    <= d1_d;
            vld2_q  <= vld2_d;
            last2_q <= last2_d;
            sub2_q  <= sub2_d;
            ab2_q   <= ab2_d;
            cd2_q   <= cd2_d;
            vld3_q  <= vld3_d;
            last3_q <= last3_d;
            sum3_q  <= sum3_d;
        end
    end

    // Stage 4: frame state and accumulator.
    frame_state_e            state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    fovf_q, fovf_d;
    logic                    add_ovf;
    logic                    fire;

    // Next frame state and accumulator: FIRST loads, ACCUM adds; a last sample closes the frame.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        fovf_d  = fovf_q;
        acc_sum = acc_q + sum3_q;
        add_ovf = (acc_q[ACC_W-1] == sum3_q[ACC_W-1]) && (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);
        fire    = vld3_q & last3_q;
        if (vld3_q) begin
            if (state_q == FIRST) begin
                acc_d  = sum3_q;
                cnt_d  = CNT_W'(1);
                fovf_d = 1'b0;
            end else begin
                acc_d  = acc_sum;
                cnt_d  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                fovf_d = fovf_q | add_ovf;
            end
            state_d = last3_q ? FIRST : ACCUM;
        end
    end

    // Frame state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    // Accumulator, sample count and sticky overflow registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            fovf_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            fovf_q <= fovf_d;
        end
    end

    // The closing sample's accumulator value goes straight to the scaler in the same cycle.
    dual_mac_scale #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT),
        .CNT_W (CNT_W)
    ) u_scale (
        .clock     (clock),
        .reset_n   (reset_n),
        .fire_vld  (fire),
        .acc_dat   (acc_d),
        .acc_ovf   (fovf_d),
        .cnt_dat   (cnt_d),
        .p         (p),
        .out_valid (out_valid),
        .out_count (out_count),
        .ovf       (ovf)
    );

endmodule

// File: tb/tb_dual_mac_frame.sv
// tb_dual_mac_frame: random and directed frames into two dual_mac_frame instances (SHIFT=0 and SHIFT=16).
// Expected frames come from an integer reference model and are queued; a monitor pops them at out_valid.
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.

module tb_dual_mac_frame;
    import dual_mac_pkg::*;

`ifdef DUAL_MAC_ROUND_SAT_EN
    localparam int LAT = LAT_BASE + 1;
`else
    localparam int LAT = LAT_BASE;
`endif

    logic               clock = 1'b0;
    logic               reset_n;
    logic               in_valid, in_last, sub;
    logic signed [25:0] a, c;
    logic signed [17:0] b, d;
    logic signed [31:0] p0, p16;
    logic               ov0, ov16, ovf0, ovf16;
    logic [15:0]        cnt0, cnt16;

    int cyc = 0;
    int n_pass = 0;
    int n_checks = 0;

    typedef struct {
        longint p;
        longint cnt;
        bit     ovf;
        int     cyc;
    } exp_t;

    exp_t  sb[2][$];
    string nm[2] = '{"shift0", "shift16"};

    // Reference model frame state.
    longint m_acc;
    bit     m_ovf;
    int     m_n;
    bit     m_active;

    dual_mac_frame #(.SHIFT(0)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_last(in_last), .sub(sub),
        .a(a), .b(b), .c(c), .d(d),
        .p(p0), .out_valid(ov0), .out_count(cnt0), .ovf(ovf0)
    );

    dual_mac_frame #(.SHIFT(16)) u_dut16 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_last(in_last), .sub(sub),
        .a(a), .b(b), .c(c), .d(d),
        .p(p16), .out_valid(ov16), .out_count(cnt16), .ovf(ovf16)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic longint wrapw(input longint v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    function automatic longint rnd_s(input int w);
        return wrapw(longint'($urandom), w);
    endfunction

    // Accumulator value -> output value and scaling flag, from the arithmetic rules.
    function automatic void scale_model(input longint acc, input int sh, output longint pv, output bit ov);
        longint q;
        longint hi;
        longint lo;
        hi = (longint'(1) <<< 31) - 1;
        lo = -(longint'(1) <<< 31);
`ifdef DUAL_MAC_ROUND_SAT_EN
        q = (sh > 0) ? ((acc + (longint'(1) <<< (sh - 1))) >>> sh) : acc;
        if (q > hi) begin
            pv = hi;
            ov = 1'b1;
        end else if (q < lo) begin
            pv = lo;
            ov = 1'b1;
        end else begin
            pv = q;
            ov = 1'b0;
        end
`else
        q  = acc >>> sh;
        pv = wrapw(q, 32);
        ov = (pv != q);
`endif
    endfunction

    task automatic check(input string name, input longint act, input longint want);
        n_checks++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, want);
    endtask

    task automatic push_expect();
        exp_t   e;
        longint pv;
        bit     ov;
        for (int k = 0; k < 2; k++) begin
            scale_model(m_acc, (k == 0) ? 0 : 16, pv, ov);
            e.p   = pv;
            e.cnt = (m_n > 65535) ? 65535 : m_n;
            e.ovf = m_ovf | ov;
            e.cyc = cyc + LAT;
            sb[k].push_back(e);
        end
    endtask

    // One valid sample for one cycle; the model folds it into the running frame.
    task automatic sample(input longint av, input longint bv, input longint cv, input longint dv,
                          input bit sv, input bit lv);
        longint s;
        longint t;
        a        = 26'(av);
        b        = 18'(bv);
        c        = 26'(cv);
        d        = 18'(dv);
        sub      = sv;
        in_last  = lv;
        in_valid = 1'b1;
        s = sv ? (av * bv - cv * dv) : (av * bv + cv * dv);
        if (!m_active) begin
            m_acc = s;
            m_ovf = 1'b0;
            m_n   = 1;
        end else begin
            t = m_acc + s;
            if (t != wrapw(t, 48)) m_ovf = 1'b1;
            m_acc = wrapw(t, 48);
            m_n++;
        end
        m_active = !lv;
        if (lv) push_expect();
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        sub      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " shift0 p"},          longint'(p0),   0);
        check({tag, " shift0 out_valid"},  longint'(ov0),  0);
        check({tag, " shift0 out_count"},  longint'(cnt0), 0);
        check({tag, " shift0 ovf"},        longint'(ovf0), 0);
        check({tag, " shift16 p"},         longint'(p16),  0);
        check({tag, " shift16 out_valid"}, longint'(ov16), 0);
        check({tag, " shift16 out_count"}, longint'(cnt16), 0);
        check({tag, " shift16 ovf"},       longint'(ovf16), 0);
    endtask

    // Every cycle: out_valid must match whether a frame is due now; due frames are compared field by field.
    task automatic mon_step(input int k, input logic v, input logic signed [31:0] pv,
                            input logic [15:0] cv, input logic ov);
        exp_t e;
        bit   due;
        due = (sb[k].size() > 0) && (sb[k][0].cyc == cyc);
        check($sformatf("%s out_valid cyc%0d", nm[k], cyc), longint'(v), longint'(due));
        if (due) begin
            e = sb[k].pop_front();
            check($sformatf("%s p cyc%0d", nm[k], cyc),         longint'(pv), e.p);
            check($sformatf("%s out_count cyc%0d", nm[k], cyc), longint'(cv), e.cnt);
            check($sformatf("%s ovf cyc%0d", nm[k], cyc),       longint'(ov), longint'(e.ovf));
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            mon_step(0, ov0, p0, cnt0, ovf0);
            mon_step(1, ov16, p16, cnt16, ovf16);
        end
    end

    initial begin
        int len;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        sub      = 1'b0;
        a = '0; b = '0; c = '0; d = '0;
        m_active = 1'b0;
        m_acc    = 0;
        m_ovf    = 1'b0;
        m_n      = 0;
        repeat (3) @(posedge clock);
        #1;
        check_reset("por");
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Four-sample frame, constant operands.
        for (int i = 0; i < 4; i++) sample(3, 5, 2, 7, 1'b0, i == 3);
        // Single-sample subtract frame, back to back with the previous last.
        sample(100, 10, 1, 1, 1'b1, 1'b1);
        // Gapped frame followed immediately by another frame.
        sample(7, -3, 2, 2, 1'b0, 1'b0);
        idle(2);
        sample(-11, 4, 5, -6, 1'b1, 1'b0);
        idle(1);
        sample(9, 9, -1, 8, 1'b0, 1'b1);
        sample(1, 2, 3, 4, 1'b0, 1'b0);
        sample(-5, 6, 7, 8, 1'b1, 1'b1);
        // Extremes: largest products driving the accumulator past its range.
        for (int i = 0; i < 16; i++) sample(-(2**25), -(2**17), -(2**25), -(2**17), 1'b0, i == 15);
        for (int i = 0; i < 17; i++) sample(-(2**25), -(2**17), -(2**25), 2**17 - 1, 1'b1, i == 16);
        // Half-LSB values at SHIFT=16, both signs.
        sample(98304, 1, 0, 0, 1'b0, 1'b1);
        sample(-98304, 1, 0, 0, 1'b0, 1'b1);

        // Random frames with random gaps.
        for (int f = 0; f < 50; f++) begin
            len = int'($urandom_range(1, 6));
            for (int s = 0; s < len; s++) begin
                sample(rnd_s(26), rnd_s(18), rnd_s(26), rnd_s(18), bit'($urandom_range(0, 1)), s == len - 1);
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            end
        end

        // Reset in the middle of a frame: partial frame and in-flight samples are dropped.
        idle(LAT + 2);
        sample(4, 4, 1, 1, 1'b0, 1'b0);
        sample(2, 3, 0, 0, 1'b1, 1'b0);
        reset_n  = 1'b0;
        m_active = 1'b0;
        #2;
        check_reset("midframe");
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock);
        #1;
        sample(5, 5, 0, 0, 1'b0, 1'b1);

        idle(LAT + 4);
        for (int k = 0; k < 2; k++) check({nm[k], " pending frames"}, longint'(sb[k].size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
